tt_um_modn_counter: RTL and testbench
=====================================

# tt_um_modn_counter

Parametrised, runtime-programmable modulo-N counter; successor to the fixed mod-6 tile counter. It adds a loadable modulus, up/down counting, synchronous load and clear, a one-shot mode with a halt state, and a terminal-count pulse. It sits as a Tiny Tapeout user tile. Control arrives on `ui_in`, the data bus on `uio_in`, and every registered status bit goes out on `uo_out`.

## Interface
- `WIDTH`, default 3: count width, legal range 1..5. The modulus register is WIDTH+1 bits.
- `MOD_RESET`, default 6: modulus after reset, legal range 2..2^WIDTH.
- `clk` input, 1 bit: the single clock; everything is on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `ena` input, 1 bit: tile enable. While low, all state holds.
- `ui_in` input, 8 bits: control inputs.
  - [0] `cnt_en`
  - [1] `up` (1 = up, 0 = down)
  - [2] `ld_mod`
  - [3] `ld_val`
  - [4] `clr`
  - [5] `one_shot`
  - [7:6] unused
- `uio_in` input, 8 bits: data bus.
  - [WIDTH:0] is the modulus for `ld_mod`.
  - [WIDTH-1:0] is the count value for `ld_val`.
- `uo_out` output, 8 bits, all registered.
  - [WIDTH-1:0] `count`; bits [4:WIDTH] read 0.
  - [5] `tc`
  - [6] `done`
  - [7] reads 0.
- `uio_out` output, 8 bits: constant 0.
- `uio_oe` output, 8 bits: constant 0 (all uio pins are inputs).

## Operation
- Registers:
  - `count` (WIDTH bits)
  - `mod` (N, WIDTH+1 bits)
  - `state` (RUN or HALT)
  - `tc` (1 bit)
- Terminal value T is N-1 when `up`=1 and 0 when `up`=0. T is evaluated every cycle from the live `up` input.
- Per-edge priority when `ena`=1 (exactly one action per cycle; lower-priority requests are dropped):
  1. `clr`: count←0, state←RUN.
  2. `ld_mod`: if 2 ≤ `uio_in[WIDTH:0]` ≤ 2^WIDTH, then mod←value, count←0, state←RUN. Any other value is ignored entirely and nothing changes.
  3. `ld_val`: count←min(`uio_in[WIDTH-1:0]`, N-1), state←RUN.
  4. Count step, taken when `cnt_en`=1 and state=RUN:
     - Up: N-1 wraps to 0; otherwise count+1.
     - Down: 0 wraps to N-1; otherwise count-1.
  5. Otherwise hold.
- `tc`←1 on any edge where a count step lands count on T. Otherwise `tc`←0, so it is a one-cycle pulse per landing. Loads and clears never set `tc`.
- One-shot (`one_shot`=1): a count step landing on T also moves state RUN→HALT.
  - A step taken from T itself wraps normally; only *landing* on T halts.
- HALT behaviour:
  - count holds and `cnt_en` is ignored.
  - Leaves via `clr`, `ld_mod` or `ld_val`, each returning to RUN as in the priority list.
  - If `one_shot` is sampled 0 while in HALT, state returns to RUN and count holds; counting resumes on the next enabled edge.
- `done` = (state == HALT).
- Arithmetic is modulo N only; count never exceeds N-1.
- Changing `up` mid-count is legal; the next step uses the new direction.
- N = 2^WIDTH is legal, and the wrap then equals natural overflow.
- `ena`=0 freezes every register, `tc` included (a pulse is stretched).

## Timing
- Reset values (asynchronous, immediate):
  - count=0, mod=MOD_RESET, state=RUN, tc=0.
  - `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0x00.
- Inputs are sampled on the rising edge. Results are visible on `uo_out` immediately after that edge, with one-cycle latency and no combinational input-to-output path.
- Reset deassertion: the first counting edge is the first rising edge with `rst_n`=1.
- Reset mid-operation: all registers return to reset values at once, and any in-progress HALT or loaded modulus is lost.

## Test plan
- **Reset default:** release reset with `ena`=1, `cnt_en`=1, `up`=1 → count 1,2,3,4,5,0,1…; `tc`=1 only in the cycles count=5; `uo_out` = 0x01,0x02,0x03,0x04,0x25,0x00.
- **Modulus load and clamping:**
  - `ld_mod` with `uio_in`=4 → count 0, then 1,2,3,0.
  - `ld_mod` with 9 → ignored; modulus stays 4.
  - `ld_mod` with 1 → ignored.
  - `ld_val` with 7 under N=4 → count 3.
- **Down counting:** N=6, `up`=0 from count 0 → 5,4,3,2,1,0,5; `tc` pulses when count lands on 0.
- **One-shot:** N=6, `up`=1, `one_shot`=1 from 0 → 1..5; `done`=1 (`uo_out`=0x65 on the landing cycle, then 0x45). Count holds at 5 with `cnt_en`=1. Then `clr` → count 0, `done`=0.
- **Priority:** assert `clr`+`ld_mod`+`ld_val` together → only the clear takes effect. Assert `ld_mod`(5)+`ld_val`(2) → count 0, N=5.
- **ena/reset:**
  - `ena`=0 for 3 cycles at count=5 with `tc`=1 → `uo_out` frozen at 0x25.
  - Assert `rst_n`=0 asynchronously mid-cycle → `uo_out`=0x00 immediately, and N reverts to 6.

Source files
------------

// File: rtl/tt_um_modn_counter.sv
// Runtime-programmable modulo-N up/down counter tile with load, clear, one-shot halt and terminal-count pulse.
// Latency: one cycle from sampled ui_in/uio_in to uo_out; no backpressure, ena=0 freezes all state.
module tt_um_modn_counter #(
    parameter int WIDTH     = 3,
    parameter int MOD_RESET = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [WIDTH:0] MOD_INIT = MOD_RESET[WIDTH:0];
    localparam logic [WIDTH:0] MOD_MIN  = (WIDTH+1)'(2);
    localparam logic [WIDTH:0] MOD_MAX  = {1'b1, {WIDTH{1'b0}}};

    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   mod_q;
    state_t           state;
    logic             tc;

    logic             cnt_en, up, ld_mod, ld_val, clr, one_shot;
    logic [WIDTH:0]   mod_in;
    logic             mod_ok;
    logic [WIDTH:0]   mod_m1;
    logic [WIDTH-1:0] nmax;
    logic [WIDTH-1:0] val_in;
    logic [WIDTH-1:0] val_clamped;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] term;
    logic             landed;

    assign cnt_en   = ui_in[0];
    assign up       = ui_in[1];
    assign ld_mod   = ui_in[2];
    assign ld_val   = ui_in[3];
    assign clr      = ui_in[4];
    assign one_shot = ui_in[5];

    assign mod_in = uio_in[WIDTH:0];
    assign mod_ok = (mod_in >= MOD_MIN) && (mod_in <= MOD_MAX);

    // mod_q never exceeds 2^WIDTH, so N-1 always fits in the count width.
    assign mod_m1 = mod_q - 1'b1;
    assign nmax   = mod_m1[WIDTH-1:0];

    assign val_in      = uio_in[WIDTH-1:0];
    assign val_clamped = (val_in > nmax) ? nmax : val_in;

    assign step_val = up ? ((count == nmax) ? '0 : count + 1'b1)
                         : ((count == '0) ? nmax : count - 1'b1);
    assign term     = up ? nmax : '0;
    assign landed   = (step_val == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            mod_q <= MOD_INIT;
            state <= RUN;
            tc    <= 1'b0;
        end else if (ena) begin
            tc <= 1'b0;
            if (clr) begin
                count <= '0;
                state <= RUN;
            end else if (ld_mod) begin
                // An out-of-range modulus still consumes the cycle's action slot.
                if (mod_ok) begin
                    mod_q <= mod_in;
                    count <= '0;
                    state <= RUN;
                end
            end else if (ld_val) begin
                count <= val_clamped;
                state <= RUN;
            end else if (state == HALT) begin
                if (!one_shot) state <= RUN;
            end else if (cnt_en) begin
                count <= step_val;
                tc    <= landed;
                if (one_shot && landed) state <= HALT;
            end
        end
    end

    always_comb begin
        uo_out              = 8'h00;
        uo_out[WIDTH-1:0]   = count;
        uo_out[5]           = tc;
        uo_out[6]           = (state == HALT);
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_bits;
    assign unused_bits = &{1'b0, ui_in[7:6], uio_in[7:WIDTH+1], mod_m1[WIDTH]};

endmodule

// File: tb/tb_tt_um_modn_counter.sv
module tb_tt_um_modn_counter;

    localparam logic [7:0] CNT = 8'h01;
    localparam logic [7:0] UP  = 8'h02;
    localparam logic [7:0] LDM = 8'h04;
    localparam logic [7:0] LDV = 8'h08;
    localparam logic [7:0] CLR = 8'h10;
    localparam logic [7:0] OS  = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int passes = 0;
    int total  = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    tt_um_modn_counter #(.WIDTH(3), .MOD_RESET(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input logic [7:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_head();
        logic [7:0] e;
        string      t;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard: observed empty queue, required an expected entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (uo_out === e) passes++;
            else $error("FAIL %s: uo_out observed %h expected %h", t, uo_out, e);
        end
    endtask

    task automatic cyc(input logic [7:0] ui, input logic [7:0] d,
                       input logic [7:0] e, input string t);
        ui_in  = ui;
        uio_in = d;
        expect_out(e, t);
        @(posedge clk);
        #1;
        check_head();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_out(8'h00, "reset_uo");
        check_head();
        total++;
        assert ({uio_out, uio_oe} === 16'h0000) passes++;
        else $error("FAIL reset_uio: observed %h expected 0000", {uio_out, uio_oe});

        rst_n = 1'b1;
        cyc(CNT|UP, 0, 8'h01, "rst_c1");
        cyc(CNT|UP, 0, 8'h02, "rst_c2");
        cyc(CNT|UP, 0, 8'h03, "rst_c3");
        cyc(CNT|UP, 0, 8'h04, "rst_c4");
        cyc(CNT|UP, 0, 8'h25, "rst_c5_tc");
        cyc(CNT|UP, 0, 8'h00, "rst_wrap");
        cyc(CNT|UP, 0, 8'h01, "rst_c1b");

        cyc(LDM, 8'd4, 8'h00, "ldmod4");
        cyc(CNT|UP, 0, 8'h01, "n4_c1");
        cyc(CNT|UP, 0, 8'h02, "n4_c2");
        cyc(CNT|UP, 0, 8'h23, "n4_c3_tc");
        cyc(CNT|UP, 0, 8'h00, "n4_wrap");
        cyc(LDM, 8'd9, 8'h00, "ldmod9_ign");
        cyc(CNT|UP, 0, 8'h01, "n4b_c1");
        cyc(CNT|UP, 0, 8'h02, "n4b_c2");
        cyc(CNT|UP, 0, 8'h23, "n4b_c3_tc");
        cyc(CNT|UP, 0, 8'h00, "n4b_wrap");
        cyc(LDM, 8'd1, 8'h00, "ldmod1_ign");
        cyc(CNT|UP, 0, 8'h01, "n4c_c1");
        cyc(LDV, 8'd7, 8'h03, "ldval7_clamp");
        cyc(CNT|UP, 0, 8'h00, "n4_wrap_from3");

        cyc(LDM, 8'd6, 8'h00, "ldmod6");
        cyc(CNT, 0, 8'h05, "dn_5");
        cyc(CNT, 0, 8'h04, "dn_4");
        cyc(CNT, 0, 8'h03, "dn_3");
        cyc(CNT, 0, 8'h02, "dn_2");
        cyc(CNT, 0, 8'h01, "dn_1");
        cyc(CNT, 0, 8'h20, "dn_0_tc");
        cyc(CNT, 0, 8'h05, "dn_wrap");

        cyc(CLR, 0, 8'h00, "clr");
        cyc(CNT|UP|OS, 0, 8'h01, "os_1");
        cyc(CNT|UP|OS, 0, 8'h02, "os_2");
        cyc(CNT|UP|OS, 0, 8'h03, "os_3");
        cyc(CNT|UP|OS, 0, 8'h04, "os_4");
        cyc(CNT|UP|OS, 0, 8'h65, "os_land");
        cyc(CNT|UP|OS, 0, 8'h45, "os_halt1");
        cyc(CNT|UP|OS, 0, 8'h45, "os_halt2");
        cyc(CLR|OS, 0, 8'h00, "os_clr");
        cyc(CNT|UP|OS, 0, 8'h01, "os2_1");
        cyc(CNT|UP|OS, 0, 8'h02, "os2_2");
        cyc(CNT|UP|OS, 0, 8'h03, "os2_3");
        cyc(CNT|UP|OS, 0, 8'h04, "os2_4");
        cyc(CNT|UP|OS, 0, 8'h65, "os2_land");
        cyc(CNT|UP, 0, 8'h05, "os_release");
        cyc(CNT|UP, 0, 8'h00, "os_resume_wrap");

        cyc(CNT|UP, 0, 8'h01, "pri_pre");
        cyc(CLR|LDM|LDV, 8'd3, 8'h00, "pri_clr");
        cyc(CNT|UP, 0, 8'h01, "pri_n6_1");
        cyc(CNT|UP, 0, 8'h02, "pri_n6_2");
        cyc(CNT|UP, 0, 8'h03, "pri_n6_3");
        cyc(CNT|UP, 0, 8'h04, "pri_n6_4");
        cyc(CNT|UP, 0, 8'h25, "pri_n6_5");
        cyc(LDM|LDV, 8'd5, 8'h00, "pri_ldm");
        cyc(CNT|UP, 0, 8'h01, "n5_1");
        cyc(CNT|UP, 0, 8'h02, "n5_2");
        cyc(CNT|UP, 0, 8'h03, "n5_3");
        cyc(CNT|UP, 0, 8'h24, "n5_4_tc");
        cyc(CNT|UP, 0, 8'h00, "n5_wrap");

        cyc(LDM, 8'd6, 8'h00, "ldmod6b");
        cyc(CNT|UP, 0, 8'h01, "e_1");
        cyc(CNT|UP, 0, 8'h02, "e_2");
        cyc(CNT|UP, 0, 8'h03, "e_3");
        cyc(CNT|UP, 0, 8'h04, "e_4");
        cyc(CNT|UP, 0, 8'h25, "e_5_tc");
        ena = 1'b0;
        cyc(CNT|UP, 0, 8'h25, "ena0_a");
        cyc(CNT|UP, 0, 8'h25, "ena0_b");
        cyc(CNT|UP, 0, 8'h25, "ena0_c");
        ena = 1'b1;
        cyc(CNT|UP, 0, 8'h00, "ena1_wrap");
        cyc(CNT|UP, 0, 8'h01, "r_1");
        cyc(LDM, 8'd4, 8'h00, "r_ldmod4");
        cyc(CNT|UP, 0, 8'h01, "r_n4_1");
        cyc(CNT|UP, 0, 8'h02, "r_n4_2");

        #2;
        rst_n = 1'b0;
        #1;
        expect_out(8'h00, "async_rst");
        check_head();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(CNT|UP, 0, 8'h01, "pr_1");
        cyc(CNT|UP, 0, 8'h02, "pr_2");
        cyc(CNT|UP, 0, 8'h03, "pr_3_n6");
        cyc(CNT|UP, 0, 8'h04, "pr_4");
        cyc(CNT|UP, 0, 8'h25, "pr_5_tc");
        cyc(CNT|UP, 0, 8'h00, "pr_wrap");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
